// File: rtl/pes_4_1_tdm_mux.sv
// Purpose : 4:1 time-division multiplexer; each lane owns DIV enabled clocks, plus a manual lane override.
// Latency : one clock from the selected lane input to y; sel, y_valid and frame are also registered.
// Backpres: none; en low freezes y/sel/slot counter (y_valid drops), man high freezes slot sequencing.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   en              advance/sample enable
//   man, man_sel    manual mode and the lane it selects
//   i0..i3          data lanes (WIDTH bits each)
//   y               registered data of the effective lane
//   sel             current automatic slot index
//   y_valid         en delayed by one clock
//   frame           one-cycle pulse after the slot 3 -> 0 wrap
module pes_4_1_tdm_mux #(
    parameter int WIDTH = 1,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             man,
    input  logic [1:0]       man_sel,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       sel,
    output logic             y_valid,
    output logic             frame
);

    // Slot counter is at least one bit wide so DIV=1 still has a legal (constant-zero) counter.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_sel;
    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;
    logic             r_frame;

    logic [1:0]       w_sel_eff;
    logic [WIDTH-1:0] w_lane;
    logic             w_slot_last;

    // man_sel only matters in manual mode; otherwise the automatic slot picks the lane.
    assign w_sel_eff   = man ? man_sel : r_sel;
    assign w_slot_last = (r_cnt == CNT_LAST);

    always_comb begin
        w_lane = i0;
        case (w_sel_eff)
            2'd0:    w_lane = i0;
            2'd1:    w_lane = i1;
            2'd2:    w_lane = i2;
            default: w_lane = i3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_sel     <= 2'd0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_y_valid <= en;
            // frame is a pulse: cleared every cycle unless this edge performs the 3 -> 0 wrap.
            r_frame   <= 1'b0;
            if (en) begin
                r_y <= w_lane;
                // Manual mode parks cnt/sel so auto sequencing resumes exactly where it left off.
                if (!man) begin
                    if (w_slot_last) begin
                        r_cnt   <= '0;
                        r_sel   <= r_sel + 2'd1;
                        r_frame <= (r_sel == 2'd3);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end
        end
    end

    assign y       = r_y;
    assign sel     = r_sel;
    assign y_valid = r_y_valid;
    assign frame   = r_frame;

endmodule
